// File: rtl/buyruk_onbellek_doldurucu_pkg.sv
// Shared definitions for the instruction-cache refill controller:
// state encoding, block geometry and the block-base mask.
package buyruk_onbellek_doldurucu_pkg;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        ISTEK = 2'd1,
        BEKLE = 2'd2,
        TAMAM = 2'd3
    } durum_e;

    localparam int OBEK_KELIME_SAYISI = 4;
    localparam int OBEK_OFSET_BIT     = 4;

    // Clears the byte offset inside a 16-byte block.
    localparam logic [31:0] OBEK_TABAN_MASKE = 32'hFFFF_FFF0;

endpackage

// File: rtl/buyruk_onbellek_doldurucu.sv
// Instruction-cache refill controller: fetches a 128-bit block as four
// sequential word reads and hands it to the cache with a one-cycle pulse.
module buyruk_onbellek_doldurucu
    import buyruk_onbellek_doldurucu_pkg::*;
#(
    parameter int ADRES_BIT  = 32,
    parameter int KELIME_BIT = 32,
    parameter int OBEK_BIT   = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  iskalama_gecerli_i,
    input  logic [ADRES_BIT-1:0]  iskalama_adres_i,
    output logic                  iskalama_hazir_o,
    input  logic                  iptal_i,
    output logic                  bellek_istek_o,
    output logic [ADRES_BIT-1:0]  bellek_adres_o,
    input  logic                  bellek_kabul_i,
    input  logic                  bellek_gecerli_i,
    input  logic [KELIME_BIT-1:0] bellek_veri_i,
    output logic [OBEK_BIT-1:0]   obek_o,
    output logic [ADRES_BIT-1:0]  obek_adres_o,
    output logic                  obek_gecerli_o,
    output logic                  mesgul_o
);

    durum_e                                          durum_q, durum_d;
    logic [1:0]                                      sayac_q, sayac_d;
    logic                                            iptal_q, iptal_d;
    logic [ADRES_BIT-1:0]                            taban_q, taban_d;
    logic [OBEK_KELIME_SAYISI-1:0][KELIME_BIT-1:0]   kelime_q, kelime_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q  <= BOS;
            sayac_q  <= 2'd0;
            iptal_q  <= 1'b0;
            taban_q  <= '0;
            kelime_q <= '0;
        end else begin
            durum_q  <= durum_d;
            sayac_q  <= sayac_d;
            iptal_q  <= iptal_d;
            taban_q  <= taban_d;
            kelime_q <= kelime_d;
        end
    end

    always_comb begin
        durum_d          = durum_q;
        sayac_d          = sayac_q;
        iptal_d          = iptal_q;
        taban_d          = taban_q;
        kelime_d         = kelime_q;
        iskalama_hazir_o = 1'b0;
        bellek_istek_o   = 1'b0;
        bellek_adres_o   = '0;
        obek_gecerli_o   = 1'b0;

        case (durum_q)
            BOS: begin
                iskalama_hazir_o = 1'b1;
                if (iskalama_gecerli_i) begin
                    taban_d = iskalama_adres_i & OBEK_TABAN_MASKE[ADRES_BIT-1:0];
                    sayac_d = 2'd0;
                    iptal_d = 1'b0;
                    durum_d = ISTEK;
                end
            end
            ISTEK: begin
                // The offset never carries out of the block, so an add is exact.
                bellek_istek_o = 1'b1;
                bellek_adres_o = taban_q + ADRES_BIT'({sayac_q, 2'b00});
                if (iptal_i) iptal_d = 1'b1;
                if (bellek_kabul_i) durum_d = BEKLE;
            end
            BEKLE: begin
                if (iptal_i) iptal_d = 1'b1;
                if (bellek_gecerli_i) begin
                    kelime_d[sayac_q] = bellek_veri_i;
                    if (sayac_q == 2'd3) begin
                        durum_d = TAMAM;
                    end else begin
                        sayac_d = sayac_q + 2'd1;
                        durum_d = ISTEK;
                    end
                end
            end
            TAMAM: begin
                // A redirect in this very cycle still suppresses the write.
                obek_gecerli_o = ~iptal_q & ~iptal_i;
                durum_d        = BOS;
            end
            default: durum_d = BOS;
        endcase
    end

    assign obek_o       = kelime_q;
    assign obek_adres_o = taban_q;
    assign mesgul_o     = (durum_q != BOS);

endmodule

// File: tb/tb_buyruk_onbellek_doldurucu.sv
// Directed + randomized bench for the refill controller with a transaction-level
// reference (block = four words, addresses = base + 4*i, latency from wait counts).
module tb_buyruk_onbellek_doldurucu;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         iskalama_gecerli_i;
    logic [31:0]  iskalama_adres_i;
    logic         iskalama_hazir_o;
    logic         iptal_i;
    logic         bellek_istek_o;
    logic [31:0]  bellek_adres_o;
    logic         bellek_kabul_i;
    logic         bellek_gecerli_i;
    logic [31:0]  bellek_veri_i;
    logic [127:0] obek_o;
    logic [31:0]  obek_adres_o;
    logic         obek_gecerli_o;
    logic         mesgul_o;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int pulses = 0;
    int exp_pulses = 0;

    buyruk_onbellek_doldurucu dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iskalama_gecerli_i(iskalama_gecerli_i), .iskalama_adres_i(iskalama_adres_i),
        .iskalama_hazir_o(iskalama_hazir_o), .iptal_i(iptal_i),
        .bellek_istek_o(bellek_istek_o), .bellek_adres_o(bellek_adres_o),
        .bellek_kabul_i(bellek_kabul_i), .bellek_gecerli_i(bellek_gecerli_i),
        .bellek_veri_i(bellek_veri_i), .obek_o(obek_o), .obek_adres_o(obek_adres_o),
        .obek_gecerli_o(obek_gecerli_o), .mesgul_o(mesgul_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (obek_gecerli_o === 1'b1) pulses <= pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (passed %0d of %0d)", passed, total);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One full refill driven from the memory side. Expected behaviour comes from
    // the transaction model: the words requested, the wait counts and the cancels.
    task automatic refill(input logic [31:0] adr, input logic [3:0][31:0] w,
                          input int kd, input int gd, input int ipt_beat,
                          input bit tamam_ipt, input bit stray, input bit hold);
        logic [31:0] base;
        int c0;
        bit  teslim;
        base   = adr & 32'hFFFF_FFF0;
        teslim = (ipt_beat < 0) && !tamam_ipt;
        iskalama_gecerli_i = 1'b1;
        iskalama_adres_i   = adr;
        #1 chk("hazir_before_miss", iskalama_hazir_o, 1);
        c0 = cyc;
        @(posedge clk_i); @(negedge clk_i);
        if (!hold) iskalama_gecerli_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < kd; k++) begin
                if (stray) begin
                    bellek_gecerli_i = 1'b1;
                    bellek_veri_i    = $urandom;
                end
                #1;
                chk("istek_wait", bellek_istek_o, 1);
                chk("adres_stable", bellek_adres_o, base + 32'(4 * b));
                chk("hazir_busy", iskalama_hazir_o, 0);
                @(posedge clk_i); @(negedge clk_i);
            end
            bellek_gecerli_i = 1'b0;
            bellek_kabul_i   = 1'b1;
            #1;
            chk("istek_accept", bellek_istek_o, 1);
            chk("adres_accept", bellek_adres_o, base + 32'(4 * b));
            @(posedge clk_i); @(negedge clk_i);
            bellek_kabul_i = 1'b0;
            chk("istek_low_in_wait", bellek_istek_o, 0);
            iptal_i = (b == ipt_beat);
            for (int k = 0; k < gd; k++) begin
                @(posedge clk_i); @(negedge clk_i);
                iptal_i = 1'b0;
            end
            bellek_gecerli_i = 1'b1;
            bellek_veri_i    = w[b];
            @(posedge clk_i); @(negedge clk_i);
            bellek_gecerli_i = 1'b0;
            iptal_i          = 1'b0;
        end
        iptal_i = tamam_ipt;
        #1;
        chk("obek_gecerli_done", obek_gecerli_o, teslim);
        chk("latency", cyc - c0, 9 + 4 * (kd + gd));
        chk("mesgul_done", mesgul_o, 1);
        if (teslim) begin
            chk("obek", obek_o, w);
            chk("obek_adres", obek_adres_o, base);
            exp_pulses++;
        end
        @(posedge clk_i); @(negedge clk_i);
        iptal_i = 1'b0;
        #1;
        chk("hazir_after", iskalama_hazir_o, 1);
        chk("mesgul_after", mesgul_o, 0);
        chk("pulse_count", pulses, exp_pulses);
    endtask

    initial begin
        logic [3:0][31:0] w;
        rst_i = 1'b1;
        iskalama_gecerli_i = 1'b0; iskalama_adres_i = '0; iptal_i = 1'b0;
        bellek_kabul_i = 1'b0; bellek_gecerli_i = 1'b0; bellek_veri_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_hazir", iskalama_hazir_o, 1);
        chk("rst_istek", bellek_istek_o, 0);
        chk("rst_adres", bellek_adres_o, 0);
        chk("rst_obek", obek_o, 0);
        chk("rst_obek_adres", obek_adres_o, 0);
        chk("rst_obek_gecerli", obek_gecerli_o, 0);
        chk("rst_mesgul", mesgul_o, 0);
        @(negedge clk_i);

        // Zero-wait refill with known data.
        w = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        refill(32'h0000_1238, w, 0, 0, -1, 0, 0, 0);
        chk("t1_block_literal", obek_o, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_base_literal", obek_adres_o, 32'h1230);

        // Wait states on both handshakes.
        w = {$urandom, $urandom, $urandom, $urandom};
        refill(32'h8000_0F0C, w, 3, 2, -1, 0, 0, 0);

        // Cancel during beat 2 wait; then cancel in the completion cycle.
        w = {$urandom, $urandom, $urandom, $urandom};
        refill($urandom, w, 1, 1, 1, 0, 0, 0);
        w = {$urandom, $urandom, $urandom, $urandom};
        refill($urandom, w, 0, 0, -1, 1, 0, 0);
        w = {$urandom, $urandom, $urandom, $urandom};
        refill($urandom, w, 0, 0, -1, 0, 0, 0);

        // Miss held high across a refill, with stray data during requests.
        w = {$urandom, $urandom, $urandom, $urandom};
        refill(32'h0000_4444, w, 2, 0, -1, 0, 1, 1);
        w = {$urandom, $urandom, $urandom, $urandom};
        refill(32'h0000_4444, w, 1, 1, -1, 0, 1, 0);

        // Randomized refills.
        for (int r = 0; r < 6; r++) begin
            int kd, gd, ib;
            bit ti;
            kd = $urandom_range(0, 2);
            gd = $urandom_range(0, 2);
            ib = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            ti = ($urandom_range(0, 3) == 0);
            w = {$urandom, $urandom, $urandom, $urandom};
            refill($urandom, w, kd, gd, ib, ti, $urandom_range(0, 1), 0);
        end

        // Reset during beat 1 wait; late data must be ignored.
        iskalama_gecerli_i = 1'b1;
        iskalama_adres_i   = 32'hDEAD_BEE4;
        @(posedge clk_i); @(negedge clk_i);
        iskalama_gecerli_i = 1'b0;
        bellek_kabul_i     = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        bellek_kabul_i = 1'b0;
        rst_i          = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_hazir", iskalama_hazir_o, 1);
        chk("mid_rst_istek", bellek_istek_o, 0);
        chk("mid_rst_adres", bellek_adres_o, 0);
        chk("mid_rst_obek", obek_o, 0);
        chk("mid_rst_obek_adres", obek_adres_o, 0);
        chk("mid_rst_mesgul", mesgul_o, 0);
        bellek_gecerli_i = 1'b1;
        bellek_veri_i    = 32'h1234_5678;
        @(posedge clk_i); @(negedge clk_i);
        bellek_gecerli_i = 1'b0;
        #1;
        chk("late_data_obek", obek_o, 0);
        chk("late_data_mesgul", mesgul_o, 0);
        chk("late_data_gecerli", obek_gecerli_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/buyruk_onbellek_doldurucu.md
Name: buyruk_onbellek_doldurucu

Overview:
- Refill controller directly upstream of the instruction cache.
- On a cache miss it fetches the 128-bit block containing the missed address from main memory as four sequential 32-bit word reads.
- It assembles the four words and presents the block to the cache with a one-cycle completion pulse.
- Supports cancellation on a fetch redirect, e.g. branch misprediction: memory is drained, the block is discarded.

Parameters:
ADRES_BIT, 32, address width
KELIME_BIT, 32, memory data word width
OBEK_BIT, 128, cache block width; words per block = OBEK_BIT/KELIME_BIT = 4

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
iskalama_gecerli_i  in  1  cache reports miss, request valid
iskalama_adres_i  in  ADRES_BIT  missed fetch address
iskalama_hazir_o  out  1  controller idle, can accept a miss
iptal_i  in  1  cancel current refill (fetch redirect)
bellek_istek_o  out  1  memory read request valid
bellek_adres_o  out  ADRES_BIT  word address of current read
bellek_kabul_i  in  1  memory accepted request
bellek_gecerli_i  in  1  memory read data valid
bellek_veri_i  in  KELIME_BIT  memory read data
obek_o  out  OBEK_BIT  assembled block; word i at bits [32i+31:32i]
obek_adres_o  out  ADRES_BIT  block base address, low 4 bits zero
obek_gecerli_o  out  1  one-cycle pulse: block complete, write to cache
mesgul_o  out  1  refill in progress

Behaviour:
- Reset: state BOS; word counter 0; iptal flag 0.
- Reset: all outputs 0, except iskalama_hazir_o=1 (state BOS).
- Reset mid-refill aborts immediately. Memory-side responses arriving afterwards are ignored (they are not in BEKLE).
- States: BOS, ISTEK, BEKLE, TAMAM.
- BOS:
  - iskalama_hazir_o=1.
  - If iskalama_gecerli_i=1: latch base={adres[31:4],4'b0}; counter=0; clear iptal flag; go to ISTEK.
  - iptal_i is ignored in BOS.
- ISTEK:
  - bellek_istek_o=1, bellek_adres_o=base+4*counter; both held stable until bellek_kabul_i=1.
  - On kabul, go to BEKLE.
- BEKLE:
  - bellek_istek_o=0.
  - On bellek_gecerli_i=1: store bellek_veri_i into word slot[counter].
  - If counter==3, go to TAMAM; otherwise counter+1 and go to ISTEK.
  - bellek_gecerli_i outside BEKLE is ignored.
  - Only one request outstanding at any time.
- TAMAM:
  - obek_gecerli_o = ~iptal_flag & ~iptal_i, for exactly one cycle.
  - Then go to BOS.
- iptal_i in ISTEK or BEKLE:
  - Sets iptal flag (sticky until next accepted miss).
  - The refill continues all 4 beats so memory is drained; obek_gecerli_o is suppressed.
- mesgul_o = state≠BOS.
- obek_o and obek_adres_o hold their last value after TAMAM until the next accepted miss overwrites them.
- Minimum latency, zero-wait memory (kabul in the first ISTEK cycle, gecerli in the first BEKLE cycle):
  - miss accepted at edge 0; word reads occupy 8 cycles; obek_gecerli_o high in cycle 9.
  - iskalama_hazir_o high again in cycle 10.
- Wait states in either handshake stretch ISTEK or BEKLE without limit. There is no timeout.
- Address wrap: base+12 never crosses the block, so no carry beyond bit 3 is possible.

Decomposition:
- Shared package holds:
  - state encoding: BOS=2'd0, ISTEK=2'd1, BEKLE=2'd2, TAMAM=2'd3;
  - constants OBEK_KELIME_SAYISI=4 and OBEK_OFSET_BIT=4;
  - the block-base mask.
- No sub-module: the FSM, 2-bit counter and four 32-bit word registers are one flat block.

Test Plan:
1. Zero-wait refill:
   - Stimulus: miss at 0x0000_1238; memory returns 0xA0,0xA1,0xA2,0xA3.
   - Required: read addresses 0x1230,0x1234,0x1238,0x123C; obek_o=0x000000A3_000000A2_000000A1_000000A0; obek_adres_o=0x1230; obek_gecerli_o high for exactly one cycle, 9 cycles after accept.
2. Wait states:
   - Stimulus: kabul delayed 3 cycles and gecerli delayed 2 cycles on every beat.
   - Required: bellek_adres_o stable while istek=1; same block result; completion at cycle 9+4*5.
3. Cancel mid-refill:
   - Stimulus: iptal_i pulsed during beat 2 BEKLE.
   - Required: all 4 requests still issued; obek_gecerli_o never asserts; iskalama_hazir_o returns to 1.
4. Cancel in TAMAM cycle:
   - Stimulus: iptal_i=1 in the TAMAM cycle.
   - Required: obek_gecerli_o=0 in that cycle.
   - Stimulus: next miss.
   - Required: completes normally with the iptal flag cleared.
5. Miss while busy / stray data:
   - Stimulus: iskalama_gecerli_i held high during a refill; bellek_gecerli_i=1 in ISTEK.
   - Required: second miss accepted only after return to BOS; stray data not stored.
6. Reset mid-refill:
   - Stimulus: rst_i asserted during BEKLE of beat 1.
   - Required: next cycle all outputs 0 except iskalama_hazir_o=1; a late gecerli is ignored.
